ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter: serialises one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the CPU bus to the keyboard over the shared open-drain clock/data lines.
- Shares the lines with the PS/2 keyboard receiver. `busy` tells that receiver to ignore line activity.
- Handles request-to-send, device-clocked bit shifting, odd parity, ack check and timeout.

---
 rtl/ps2_host_tx.sv | 119 +++++++++++
 tb/tb_ps2_host_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with request-to-send, odd parity, ack check and timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic       wr,
    input  logic [7:0] data_in,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam int MAXC = TIMEOUT_CYCLES > INHIBIT_CYCLES ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, XFER, LINES, DONE, ERR} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0] n, n_n;
    logic [2:0] bit_idx;
    logic [7:0] tx_byte;
    logic par;
    logic [1:0] clk_s, data_s;
    logic clk_q, fall, tmo, accept;

    assign fall = clk_q & ~clk_s[1];
    assign tmo = cnt == CW'(TIMEOUT_CYCLES - 1);
    assign accept = state == IDLE && sel && wr;
    assign bit_idx = n[2:0] - 3'd1;

    // Synchronisers idle high so reset never fabricates a falling edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            n       <= '0;
            tx_byte <= '0;
            par     <= 1'b0;
            clk_s   <= 2'b11;
            data_s  <= 2'b11;
            clk_q   <= 1'b1;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            n      <= n_n;
            clk_s  <= {clk_s[0], ps2_clk};
            data_s <= {data_s[0], ps2_data};
            clk_q  <= clk_s[1];
            if (accept) begin
                tx_byte <= data_in;
                par     <= ~^data_in;
            end
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        n_n         = n;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        err         = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_n = INHIBIT;
                    cnt_n   = '0;
                end
            end
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                cnt_n      = cnt + CW'(1);
                state_n    = cnt == CW'(INHIBIT_CYCLES - 1) ? REQ : INHIBIT;
            end
            REQ: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
                state_n     = XFER;
                cnt_n       = '0;
                n_n         = '0;
            end
            XFER: begin
                // n counts device falling edges seen so far; n==0 holds the start bit.
                ps2_data_oe = n == 4'd0 ? 1'b1 : n <= 4'd8 ? ~tx_byte[bit_idx] : n == 4'd9 ? ~par : 1'b0;
                cnt_n = fall ? '0 : cnt + CW'(1);
                if (fall) begin
                    n_n = n + 4'd1;
                    if (n == 4'd10) state_n = data_s[1] ? ERR : LINES;
                end else if (tmo) begin
                    state_n = ERR;
                end
            end
            LINES: begin
                cnt_n = fall ? '0 : cnt + CW'(1);
                if (clk_s[1] && data_s[1]) state_n = DONE;
                else if (!fall && tmo) state_n = ERR;
            end
            DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_n = IDLE;
            end
            ERR: begin
                busy    = 1'b0;
                err     = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: device-model bench for ps2_host_tx with a frame table and scoreboard queue.
module tb_ps2_host_tx;
    localparam int INH = 50;
    localparam int T = 2000;
    localparam int HALF = 40;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sel = 1'b0;
    logic wr = 1'b0;
    logic [7:0] data_in = '0;
    logic ps2_clk, ps2_data, ps2_clk_oe, ps2_data_oe, busy, done, err;
    logic dev_c = 1'b0;
    logic dev_d = 1'b0;

    assign ps2_clk = ~(ps2_clk_oe | dev_c);
    assign ps2_data = ~(ps2_data_oe | dev_d);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .sel(sel), .wr(wr), .data_in(data_in),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data), .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int done_cyc = 0;
    int err_cyc = 0;
    int pulse_busy = 0;
    int err_at = 0;
    int last_fall = 0;
    int pass_cnt = 0;
    int total_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) done_cyc++;
        if (err) begin
            err_cyc++;
            err_at = cyc;
        end
        if ((done || err) && busy) pulse_busy++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] d;
        int edges;
        bit ack;
        bit extra;
        bit exp_done;
        bit tmo_chk;
    } vec_t;

    typedef struct {
        logic [9:0] oe;
        logic [9:0] mask;
        bit done;
        bit err;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h required %0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write(input logic [7:0] d);
        sel = 1'b1;
        wr = 1'b1;
        data_in = d;
        tick(1);
        sel = 1'b0;
        wr = 1'b0;
    endtask

    // Expected data_oe after edges 1..10: inverted data bits, inverted odd parity, released stop.
    function automatic logic [9:0] exp_oe(input logic [7:0] d);
        logic [9:0] r;
        logic p;
        p = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (d[i]) p = ~p;
            r[i] = ~d[i];
        end
        r[8] = ~p;
        r[9] = 1'b0;
        return r;
    endfunction

    task automatic run_device(input int edges, input bit ack, output logic [10:0] got);
        int w;
        got = '0;
        w = 0;
        while (!(ps2_clk && !ps2_data) && w < 2000) begin
            tick(1);
            w++;
        end
        check("req_seen", 32'(w < 2000), 32'd1);
        tick(20);
        check("start_bit", 32'(ps2_data_oe), 32'd1);
        for (int k = 1; k <= edges; k++) begin
            if (k == 11 && ack) begin
                dev_d = 1'b1;
                tick(5);
            end
            dev_c = 1'b1;
            last_fall = cyc;
            tick(HALF);
            got[k-1] = ps2_data_oe;
            dev_c = 1'b0;
            if (k == 11) tick(2);
            dev_d = 1'b0;
            tick(HALF);
        end
    endtask

    task automatic do_frame(input vec_t v);
        exp_t e;
        int d0, e0, p0;
        logic [10:0] got;
        e.oe = exp_oe(v.d);
        e.mask = v.edges >= 10 ? 10'h3FF : 10'((1 << v.edges) - 1);
        e.done = v.exp_done;
        e.err = !v.exp_done;
        sb.push_back(e);
        d0 = done_cyc;
        e0 = err_cyc;
        p0 = pulse_busy;
        write(v.d);
        if (v.extra) begin
            tick(5);
            check("busy_during_frame", 32'(busy), 32'd1);
            write(8'h55);
        end
        run_device(v.edges, v.ack, got);
        for (int i = 0; i < T + 200 && done_cyc == d0 && err_cyc == e0; i++) tick(1);
        tick(3);
        e = sb.pop_front();
        check($sformatf("oe_bits_%02h", v.d), 32'(got[9:0] & e.mask), 32'(e.oe & e.mask));
        check($sformatf("done_cycles_%02h", v.d), 32'(done_cyc - d0), 32'(e.done));
        check($sformatf("err_cycles_%02h", v.d), 32'(err_cyc - e0), 32'(e.err));
        check("busy_at_pulse", 32'(pulse_busy - p0), 32'd0);
        check("idle_after", 32'({busy, ps2_clk_oe, ps2_data_oe}), 32'd0);
        if (v.tmo_chk) check("tmo_after_last_edge", 32'(err_at - last_fall), 32'(T + 3));
    endtask

    initial begin
        vec_t vt[5];
        logic [10:0] got;
        int n_inh, w, d0, e0;
        vt[0] = '{8'hED, 11, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[1] = '{8'h07, 11, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[2] = '{8'h00, 11, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[3] = '{8'hED, 11, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[4] = '{8'hA5, 5, 1'b1, 1'b0, 1'b0, 1'b1};

        tick(3);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        tick(2);

        for (int i = 0; i < 5; i++) do_frame(vt[i]);

        // Request timing and a device that never clocks.
        write(8'hFF);
        n_inh = 0;
        while (ps2_clk_oe && !ps2_data_oe && n_inh < 200) begin
            n_inh++;
            tick(1);
        end
        check("inhibit_cycles", 32'(n_inh), 32'(INH));
        check("req_both_low", 32'({ps2_clk_oe, ps2_data_oe}), 32'b11);
        tick(1);
        check("wait_lines", 32'({ps2_clk_oe, ps2_data_oe, busy}), 32'b011);
        w = 0;
        while (!err && w < T + 100) begin
            tick(1);
            w++;
        end
        check("wait_timeout_cycles", 32'(w), 32'(T));
        check("timeout_release", 32'({ps2_clk_oe, ps2_data_oe, busy}), 32'd0);
        tick(1);
        check("err_one_cycle", 32'(err), 32'd0);
        tick(3);

        // Reset in the middle of a frame.
        d0 = done_cyc;
        e0 = err_cyc;
        write(8'h3C);
        run_device(4, 1'b1, got);
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        tick(1);
        check("midrst_lines", 32'({ps2_clk_oe, ps2_data_oe, busy}), 32'd0);
        tick(2);
        rst = 1'b1;
        tick(20);
        check("midrst_no_pulse", 32'((done_cyc - d0) + (err_cyc - e0)), 32'd0);
        do_frame('{8'hF4, 11, 1'b1, 1'b0, 1'b1, 1'b0});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
